// File: rtl/difftest_commit_gen.sv
// Difftest commit producer: buffers sparse ROB retire-slot records in a circular
// buffer and emits them as a compacted, lane-ordered commit vector each cycle.
module difftest_commit_gen #(
  parameter int unsigned CONFIG_P_COMMIT_WIDTH = 1,
  parameter int unsigned CONFIG_P_DEPTH        = 3
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0]    i_valid,
  input  logic [(1<<CONFIG_P_COMMIT_WIDTH)*30-1:0] i_pc,
  input  logic [(1<<CONFIG_P_COMMIT_WIDTH)*32-1:0] i_insn,
  input  logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0]    i_wen,
  input  logic [(1<<CONFIG_P_COMMIT_WIDTH)*5-1:0]  i_wnum,
  input  logic [(1<<CONFIG_P_COMMIT_WIDTH)*32-1:0] i_wdata,
  input  logic                                     i_hold,
  output logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0]    o_valid,
  output logic [(1<<CONFIG_P_COMMIT_WIDTH)*30-1:0] o_pc,
  output logic [(1<<CONFIG_P_COMMIT_WIDTH)*32-1:0] o_insn,
  output logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0]    o_wen,
  output logic [(1<<CONFIG_P_COMMIT_WIDTH)*5-1:0]  o_wnum,
  output logic [(1<<CONFIG_P_COMMIT_WIDTH)*32-1:0] o_wdata,
  output logic [CONFIG_P_DEPTH:0]                  o_count,
  output logic                                     o_overflow
);

  localparam int unsigned W     = 1 << CONFIG_P_COMMIT_WIDTH;
  localparam int unsigned D     = 1 << CONFIG_P_DEPTH;
  localparam int unsigned PTR_W = CONFIG_P_DEPTH;
  localparam int unsigned CNT_W = CONFIG_P_DEPTH + 1;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] insn;
    logic        wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } rec_t;

  rec_t             mem_q  [D];
  rec_t             lane_q [W];
  rec_t             lane_d [W];
  rec_t             slot_c [W];
  logic [W-1:0]     valid_q, valid_d;
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [CNT_W-1:0] k_c, free_c, n_c, kept_c;
  logic [PTR_W-1:0] pos_c  [W];
  logic             keep_c [W];

  // Unpack the flat retire-slot buses into records.
  always_comb begin
    for (int i = 0; i < W; i++) begin
      slot_c[i].pc    = i_pc[i*30 +: 30];
      slot_c[i].insn  = i_insn[i*32 +: 32];
      slot_c[i].wen   = i_wen[i];
      slot_c[i].wnum  = i_wnum[i*5 +: 5];
      slot_c[i].wdata = i_wdata[i*32 +: 32];
    end
  end

  // Pop size, free space (including this edge's pop) and compacted write slots.
  always_comb begin
    k_c = '0;
    if (!i_hold) k_c = (count_q < CNT_W'(W)) ? count_q : CNT_W'(W);
    free_c = CNT_W'(D) - count_q + k_c;
    n_c    = '0;
    for (int i = 0; i < W; i++) begin
      pos_c[i]  = n_c[PTR_W-1:0];
      keep_c[i] = i_valid[i] && (n_c < free_c);
      if (i_valid[i]) n_c = n_c + CNT_W'(1);
    end
    kept_c = (n_c < free_c) ? n_c : free_c;
  end

  // Next-state for pointers, occupancy, sticky overflow and output lanes.
  always_comb begin
    rd_d    = rd_q + k_c[PTR_W-1:0];
    wr_d    = wr_q + kept_c[PTR_W-1:0];
    count_d = count_q - k_c + kept_c;
    ovf_d   = ovf_q | (n_c > free_c);
    valid_d = '0;
    for (int j = 0; j < W; j++) begin
      lane_d[j] = '0;
      if (CNT_W'(j) < k_c) begin
        lane_d[j]  = mem_q[rd_q + PTR_W'(j)];
        valid_d[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= '0;
      for (int j = 0; j < W; j++) lane_q[j] <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      for (int j = 0; j < W; j++) lane_q[j] <= lane_d[j];
    end
  end

  // Storage is not reset; only entries between rd and wr are ever read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < W; i++) begin
        if (keep_c[i]) mem_q[wr_q + pos_c[i]] <= slot_c[i];
      end
    end
  end

  for (genvar j = 0; j < W; j++) begin : g_lane
    assign o_pc[j*30 +: 30]    = lane_q[j].pc;
    assign o_insn[j*32 +: 32]  = lane_q[j].insn;
    assign o_wen[j]            = lane_q[j].wen;
    assign o_wnum[j*5 +: 5]    = lane_q[j].wnum;
    assign o_wdata[j*32 +: 32] = lane_q[j].wdata;
  end

  assign o_valid    = valid_q;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;

endmodule
